// File: rtl/bp_be_mmu_lite_pkg.sv
// bp_be_mmu_lite_pkg: shared types and mem_op decode for the identity-mapped MMU
package bp_be_mmu_lite_pkg;
    localparam int mem_op_width_lp = 4;

    typedef enum logic [1:0] {e_mmu_ready, e_mmu_wait, e_mmu_miss} bp_be_mmu_state_e;

    typedef enum logic [3:0] {
        e_lb, e_lh, e_lw, e_ld, e_lbu, e_lhu, e_lwu, e_sb, e_sh, e_sw, e_sd
    } bp_be_mem_op_e;

    typedef struct packed {
        logic cache_miss_v;
        logic load_misaligned_v;
        logic store_misaligned_v;
    } bp_be_mmu_exception_s;

    typedef struct packed {
        logic [63:0]          data;
        bp_be_mmu_exception_s exception;
    } bp_be_mmu_resp_s;

    // Everything of the dcache packet except the parameter-sized paddr, which leads it
    typedef struct packed {
        logic [7:0]  byte_mask;
        logic [63:0] wdata;
        logic        we;
    } bp_be_dcache_pkt_s;

    function automatic logic [1:0] mem_op_lg_size(bp_be_mem_op_e op);
        return (op inside {e_lb, e_lbu, e_sb}) ? 2'd0
             : (op inside {e_lh, e_lhu, e_sh}) ? 2'd1
             : (op inside {e_lw, e_lwu, e_sw}) ? 2'd2 : 2'd3;
    endfunction

    function automatic logic mem_op_is_store(bp_be_mem_op_e op);
        return op inside {e_sb, e_sh, e_sw, e_sd};
    endfunction

    function automatic logic mem_op_is_signed(bp_be_mem_op_e op);
        return op inside {e_lb, e_lh, e_lw};
    endfunction
endpackage

// File: rtl/bp_be_mmu_lite_if.sv
// bp_be_mmu_lite_if: MMU command/response and dcache request/response bundle
interface bp_be_mmu_lite_if
    import bp_be_mmu_lite_pkg::*;
#(
    parameter int vaddr_width_p = 39,
    parameter int paddr_width_p = 39
);
    logic [mem_op_width_lp+64+vaddr_width_p-1:0]        mmu_cmd_i;
    logic                                               mmu_cmd_v_i;
    logic                                               mmu_cmd_ready_o;
    bp_be_mmu_resp_s                                    mmu_resp_o;
    logic                                               mmu_resp_v_o;
    logic [paddr_width_p+$bits(bp_be_dcache_pkt_s)-1:0] dcache_pkt_o;
    logic                                               dcache_pkt_v_o;
    logic                                               dcache_ready_i;
    logic [63:0]                                        dcache_data_i;
    logic                                               dcache_v_i;
    logic                                               dcache_miss_i;

    modport slave (
        input  mmu_cmd_i, mmu_cmd_v_i, dcache_ready_i, dcache_data_i, dcache_v_i, dcache_miss_i,
        output mmu_cmd_ready_o, mmu_resp_o, mmu_resp_v_o, dcache_pkt_o, dcache_pkt_v_o
    );

    modport master (
        output mmu_cmd_i, mmu_cmd_v_i, dcache_ready_i, dcache_data_i, dcache_v_i, dcache_miss_i,
        input  mmu_cmd_ready_o, mmu_resp_o, mmu_resp_v_o, dcache_pkt_o, dcache_pkt_v_o
    );
endinterface

// File: rtl/bp_be_load_align.sv
// bp_be_load_align: selects and sign/zero-extends a load from a doubleword-aligned read
module bp_be_load_align
    import bp_be_mmu_lite_pkg::*;
(
    input  logic [63:0]   data,
    input  logic [2:0]    offset,
    input  bp_be_mem_op_e op,
    output logic [63:0]   result
);
    logic [63:0] shifted;
    logic [1:0]  lg;
    logic        sx;

    assign shifted = data >> {offset, 3'b000};
    assign lg      = mem_op_lg_size(op);
    assign sx      = mem_op_is_signed(op);
    assign result  = (lg == 2'd0) ? {{56{sx & shifted[7]}}, shifted[7:0]}
                   : (lg == 2'd1) ? {{48{sx & shifted[15]}}, shifted[15:0]}
                   : (lg == 2'd2) ? {{32{sx & shifted[31]}}, shifted[31:0]} : shifted;
endmodule

// File: rtl/bp_be_mmu_lite.sv
// bp_be_mmu_lite: identity-mapped MMU issuing aligned loads/stores to the L1 dcache
module bp_be_mmu_lite
    import bp_be_mmu_lite_pkg::*;
#(
    parameter int vaddr_width_p             = 39,
    parameter int paddr_width_p             = 39,
    parameter int lce_sets_p                = 64,
    parameter int cce_block_size_in_bytes_p = 64
) (
    input logic             clk_i,
    input logic             reset_i,
    bp_be_mmu_lite_if.slave mmu
);
    localparam int cmd_width_lp = mem_op_width_lp + 64 + vaddr_width_p;

    if (paddr_width_p > vaddr_width_p || lce_sets_p < 1 || cce_block_size_in_bytes_p < 8) begin : g_bad_params
        $error("bp_be_mmu_lite: invalid parameters");
    end

    bp_be_mmu_state_e  state_r, state_n;
    bp_be_mem_op_e     op_r, cmd_op;
    logic [2:0]        off_r, off;
    logic              mis_r, misaligned;
    logic [63:0]       rs2, load_data;
    logic [1:0]        lg;
    logic              cmd_ready, accept, in_wait, hit, miss, st_r;
    bp_be_dcache_pkt_s pkt;

    assign cmd_op     = bp_be_mem_op_e'(mmu.mmu_cmd_i[cmd_width_lp-1 -: mem_op_width_lp]);
    assign rs2        = mmu.mmu_cmd_i[vaddr_width_p +: 64];
    assign off        = mmu.mmu_cmd_i[2:0];
    assign lg         = mem_op_lg_size(cmd_op);
    assign misaligned = ((lg == 2'd1) & off[0]) | ((lg == 2'd2) & (|off[1:0])) | ((lg == 2'd3) & (|off));
    assign cmd_ready  = (state_r == e_mmu_ready) & mmu.dcache_ready_i;
    assign accept     = mmu.mmu_cmd_v_i & cmd_ready;

    assign pkt.byte_mask = ((lg == 2'd0) ? 8'h01 : (lg == 2'd1) ? 8'h03 : (lg == 2'd2) ? 8'h0f : 8'hff) << off;
    assign pkt.wdata     = (lg == 2'd0) ? {8{rs2[7:0]}} : (lg == 2'd1) ? {4{rs2[15:0]}}
                         : (lg == 2'd2) ? {2{rs2[31:0]}} : rs2;
    assign pkt.we        = mem_op_is_store(cmd_op);

    assign mmu.mmu_cmd_ready_o = cmd_ready;
    assign mmu.dcache_pkt_o    = {mmu.mmu_cmd_i[paddr_width_p-1:0], pkt};
    assign mmu.dcache_pkt_v_o  = accept & ~misaligned;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= e_mmu_ready;
            op_r    <= e_ld;
            off_r   <= 3'd0;
            mis_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            if (accept) begin
                op_r  <= cmd_op;
                off_r <= off;
                mis_r <= misaligned;
            end
        end
    end

    // A miss outranks a simultaneous hit; a misaligned command never reached the dcache
    always_comb begin
        state_n = state_r;
        case (state_r)
            e_mmu_ready: state_n = accept ? e_mmu_wait : e_mmu_ready;
            e_mmu_wait:  state_n = mis_r ? e_mmu_ready : mmu.dcache_miss_i ? e_mmu_miss
                                 : mmu.dcache_v_i ? e_mmu_ready : e_mmu_wait;
            e_mmu_miss:  state_n = mmu.dcache_ready_i ? e_mmu_ready : e_mmu_miss;
            default:     state_n = e_mmu_ready;
        endcase
    end

    bp_be_load_align align (.data(mmu.dcache_data_i), .offset(off_r), .op(op_r), .result(load_data));

    assign in_wait = state_r == e_mmu_wait;
    assign st_r    = mem_op_is_store(op_r);
    assign miss    = in_wait & ~mis_r & mmu.dcache_miss_i;
    assign hit     = in_wait & ~mis_r & mmu.dcache_v_i & ~mmu.dcache_miss_i;

    assign mmu.mmu_resp_v_o                           = in_wait & (mis_r | mmu.dcache_v_i | mmu.dcache_miss_i);
    assign mmu.mmu_resp_o.data                        = (hit & ~st_r) ? load_data : 64'd0;
    assign mmu.mmu_resp_o.exception.cache_miss_v       = miss;
    assign mmu.mmu_resp_o.exception.load_misaligned_v  = in_wait & mis_r & ~st_r;
    assign mmu.mmu_resp_o.exception.store_misaligned_v = in_wait & mis_r & st_r;

    assert property (@(posedge clk_i) disable iff (reset_i)
        (in_wait & ~mis_r) |-> (mmu.dcache_v_i | mmu.dcache_miss_i))
        else $error("bp_be_mmu_lite: dcache gave no response in WAIT");
endmodule
